// File: rtl/apb_burst_master.sv
// APB initiator that turns one {address, length, direction} command into
// back-to-back APB transfers, fed and drained by valid/ready data streams.
module apb_burst_master #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_write,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic [31:0]      PADDR,
  output logic [31:0]      PWDATA,
  output logic             PWRITE,
  output logic             PSEL,
  output logic             PENABLE,
  input  logic [31:0]      PRDATA,
  input  logic             PREADY,
  input  logic             PSLVERR,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [LEN_W-1:0] xfer_count
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             write_q, write_d;
  logic [LEN_W-1:0] xfer_count_q, xfer_count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [LEN_W-1:0] xfer_inc;
  logic             timeout_hit;
  logic             fetch_go;

  assign xfer_inc = xfer_count_q + LEN_W'(1);

  // wait_q counts low-PREADY ACCESS cycles already spent; TIMEOUT of 0 never fires
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

  // A read beat may only start once the previous word has left (or is leaving) the output register
  assign fetch_go = write_q ? wdata_valid : (!rdata_valid_q || rdata_ready);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    write_d       = write_q;
    xfer_count_d  = xfer_count_q;
    wait_d        = wait_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q && !rdata_ready;
    err_d         = err_q;
    err_code_d    = err_code_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d       = cmd_addr & 32'hFFFF_FFFC;
          len_d        = cmd_len;
          write_d      = cmd_write;
          xfer_count_d = '0;
          err_d        = 1'b0;
          err_code_d   = 2'b00;
          state_d      = (cmd_len == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        if (fetch_go) begin
          if (write_q) begin
            pwdata_d = wdata;
          end
          paddr_d   = addr_q;
          pwrite_d  = write_q;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          wait_d    = '0;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (PSLVERR) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
            state_d    = S_DONE;
          end else begin
            if (!write_q) begin
              rdata_d       = PRDATA;
              rdata_valid_d = 1'b1;
            end
            xfer_count_d = xfer_inc;
            addr_d       = addr_q + 32'd4;
            state_d      = (xfer_inc == len_q) ? S_DONE : S_FETCH;
          end
        end else if (timeout_hit) begin
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      write_q       <= 1'b0;
      xfer_count_q  <= '0;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      write_q       <= write_d;
      xfer_count_q  <= xfer_count_d;
      wait_q        <= wait_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign wdata_ready = (state_q == S_FETCH) && write_q;

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign xfer_count  = xfer_count_q;

endmodule
